multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the KGP-RISC core. Sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Drives the enables of the PC, instruction register, register file and memory strobes; these are the DFF-based state elements of the datapath.
- Handles a variable-latency memory handshake, including a timeout, and keeps a retired-instruction count.

Parameters:
- TIMEOUT, 15, max consecutive cycles a memory strobe may wait for mem_ready before the FSM enters ERROR (legal range 1..255).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin execution; sampled only in IDLE.
- instr_class  in  3  decoder class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 HALT, 6-7 illegal.
- branch_taken  in  1  branch condition from flags, valid in EXEC.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_en  out  1  PC load enable.
- pc_sel  out  2  PC source: 0 PC+4, 1 branch target, 2 jump target.
- ir_en  out  1  IR load enable.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- is_fetch  out  1  memory address mux: 1 selects PC, 0 selects ALU result.
- reg_we  out  1  register file write enable.
- wb_sel  out  1  writeback source: 0 ALU, 1 memory.
- busy  out  1  high in every state except IDLE, HALT and ERROR.
- halted  out  1  high in HALT.
- error  out  1  high in ERROR.
- retired  out  CNT_W  completed-instruction count.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- Reset: state=IDLE, class register=0, wait counter=0, retired=0. All outputs are 0 while rst is high and immediately after it.
- Reset mid-operation drops the memory strobes asynchronously; there is no partial writeback.
- All outputs are combinational from state, the latched class, mem_ready and branch_taken. They are glitch-tolerant because all consumers are clocked.
- IDLE: start=1 -> FETCH. Otherwise stay.
- FETCH:
  - mem_rd=1, is_fetch=1.
  - When mem_ready=1: ir_en=1 in the same cycle -> DECODE.
- DECODE: latch instr_class into class_q.
  - Classes 0-4 -> EXEC.
  - Class 5 -> HALT.
  - Classes 6-7 -> ERROR.
- EXEC:
  - ALU -> WB.
  - LOAD, STORE -> MEM.
  - BRANCH: pc_en=1, pc_sel = branch_taken ? 1 : 0 -> FETCH.
  - JUMP: pc_en=1, pc_sel=2 -> FETCH.
- MEM:
  - LOAD: mem_rd=1. On mem_ready -> WB.
  - STORE: mem_wr=1. On mem_ready: pc_en=1, pc_sel=0 -> FETCH.
- WB: reg_we=1, wb_sel=(class_q==LOAD), pc_en=1, pc_sel=0 -> FETCH.
- HALT, ERROR: terminal until rst. All strobes and enables stay 0.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM.
  - It increments on each cycle in that state with mem_ready=0.
  - When the counter equals TIMEOUT and mem_ready=0, the next state is ERROR.
  - mem_ready=1 on the same cycle the counter reaches TIMEOUT wins: normal transition.
- retired:
  - Increments on each cycle with pc_en=1.
  - Saturates at all-ones; no wrap.
  - Not incremented by HALT.
- Latency with zero-wait memory, measured start-of-FETCH to next FETCH:
  - ALU 4 cycles.
  - LOAD 5.
  - STORE 4.
  - BRANCH/JUMP 3.
  - Each memory wait cycle adds 1.
- Changes on instr_class after DECODE are ignored.
- start is ignored outside IDLE.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - the state encoding, 3 bits;
  - the instr_class codes;
  - the pc_sel codes.
- One sub-module, mem_wait_timer: clear, count-enable and TIMEOUT parameter in; expired out.
- All other logic lives in multicycle_ctrl.

Test Plan:
- Reset, start pulse, ALU instruction, mem_ready tied 1 -> FETCH, DECODE, EXEC, WB.
  - ir_en on cycle 1; reg_we=1, wb_sel=0 and pc_en=1 on cycle 4.
  - retired=1 after cycle 4; next FETCH on cycle 5.
- LOAD with mem_ready delayed 2 cycles in MEM:
  - mem_rd high 3 cycles in MEM, then WB with wb_sel=1.
  - Total 7 cycles; retired=1.
- STORE -> mem_wr high in MEM, reg_we never asserted, pc_en with pc_sel=0 on the mem_ready cycle.
- BRANCH:
  - taken -> pc_sel=1 in EXEC.
  - not taken -> pc_sel=0.
  - JUMP -> pc_sel=2.
  - Each completes in 3 cycles.
- mem_ready held 0 in FETCH with TIMEOUT=15:
  - ERROR entered after 16 FETCH cycles; error=1, mem_rd=0, busy=0.
  - A repeat run with mem_ready=1 on the 16th cycle goes to DECODE instead.
- Class 5 -> halted=1, retired unchanged, start ignored.
- Class 7 -> error=1.
- rst asserted mid-MEM of a STORE -> mem_wr drops asynchronously; state=IDLE, retired=0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the KGP-RISC multi-cycle controller:
// FSM states, decoder instruction classes and PC source selects.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JUMP   = 3'd4,
        CLS_HALT   = 3'd5,
        CLS_ILL6   = 3'd6,
        CLS_ILL7   = 3'd7
    } instr_class_e;

    localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

    // States that hold a memory strobe and therefore run the wait timer.
    function automatic logic is_mem_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; expired flags that the count
// has reached TIMEOUT so the controller can abandon the access.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear dominates, count saturates rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (cnt_en && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and strobes, and counts retired instructions.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       instr_class,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             ir_en,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             is_fetch,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retired
);

    state_e             state_q;
    state_e             state_d;
    instr_class_e       class_q;
    instr_class_e       class_d;
    logic [CNT_W-1:0]   retired_q;
    logic [CNT_W-1:0]   retired_d;
    logic               in_wait_s;
    logic               timer_clr_s;
    logic               timer_en_s;
    logic               expired_s;

    // Leaving a wait state always happens on mem_ready (or timeout), so
    // clearing on ready also gives a fresh count on every state entry.
    assign in_wait_s   = is_mem_wait_state(state_q);
    assign timer_clr_s = !in_wait_s || mem_ready;
    assign timer_en_s  = in_wait_s && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr_s),
        .cnt_en  (timer_en_s),
        .expired (expired_s)
    );

    // Next-state and datapath control decode.
    always_comb begin
        state_d  = state_q;
        class_d  = class_q;
        pc_en    = 1'b0;
        pc_sel   = PC_SEL_SEQ;
        ir_en    = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        is_fetch = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        error    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                is_fetch = 1'b1;
                // A ready on the final allowed cycle still completes the fetch.
                if (mem_ready) begin
                    ir_en   = 1'b1;
                    state_d = ST_DECODE;
                end else if (expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                busy    = 1'b1;
                class_d = instr_class_e'(instr_class);
                case (instr_class_e'(instr_class))
                    CLS_ALU, CLS_LOAD, CLS_STORE,
                    CLS_BRANCH, CLS_JUMP: state_d = ST_EXEC;
                    CLS_HALT:             state_d = ST_HALT;
                    default:              state_d = ST_ERROR;
                endcase
            end
            ST_EXEC: begin
                busy = 1'b1;
                case (class_q)
                    CLS_ALU:              state_d = ST_WB;
                    CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
                    CLS_BRANCH: begin
                        pc_en   = 1'b1;
                        pc_sel  = branch_taken ? PC_SEL_BRANCH : PC_SEL_SEQ;
                        state_d = ST_FETCH;
                    end
                    CLS_JUMP: begin
                        pc_en   = 1'b1;
                        pc_sel  = PC_SEL_JUMP;
                        state_d = ST_FETCH;
                    end
                    default:              state_d = ST_ERROR;
                endcase
            end
            ST_MEM: begin
                busy = 1'b1;
                case (class_q)
                    CLS_LOAD: begin
                        mem_rd = 1'b1;
                        if (mem_ready) begin
                            state_d = ST_WB;
                        end else if (expired_s) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_MEM;
                        end
                    end
                    CLS_STORE: begin
                        mem_wr = 1'b1;
                        if (mem_ready) begin
                            pc_en   = 1'b1;
                            pc_sel  = PC_SEL_SEQ;
                            state_d = ST_FETCH;
                        end else if (expired_s) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_MEM;
                        end
                    end
                    default: state_d = ST_ERROR;
                endcase
            end
            ST_WB: begin
                busy    = 1'b1;
                reg_we  = 1'b1;
                wb_sel  = (class_q == CLS_LOAD);
                pc_en   = 1'b1;
                pc_sel  = PC_SEL_SEQ;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted  = 1'b1;
                state_d = ST_HALT;
            end
            ST_ERROR: begin
                error   = 1'b1;
                state_d = ST_ERROR;
            end
            default: begin
                error   = 1'b1;
                state_d = ST_ERROR;
            end
        endcase
    end

    // Retired count advances with every PC update and sticks at all-ones.
    always_comb begin
        if (pc_en && (retired_q != {CNT_W{1'b1}})) begin
            retired_d = retired_q + CNT_W'(1);
        end else begin
            retired_d = retired_q;
        end
    end

    // State, latched class and retired-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            class_q   <= CLS_ALU;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

endmodule
